// File: rtl/sub_pkg.sv
// sub_pkg: shared types and constants for the bit-serial ripple-borrow subtractor
//   sub_state_t        : controller states (IDLE, RUN, DONE)
//   SUB_WIDTH_DEFAULT  : default operand width, shared with the adder bench
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub_state_t;

    localparam int SUB_WIDTH_DEFAULT = 3;

endpackage

// File: rtl/full_subtractor_bit.sv
// full_subtractor_bit: one-bit combinational full subtractor cell
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow-in
//   d    : difference bit a - b - bin
//   bout : borrow-out
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or a == b and a borrow is pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/ripple_borrow_subtractor_seq.sv
// ripple_borrow_subtractor_seq: bit-serial a - b - bin, LSB first, with valid/ready handshakes
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : operand bundle valid
//   in_ready  : block can accept operands (registered)
//   a, b, bin : minuend, subtrahend, borrow-in
//   out_valid : result valid (registered)
//   out_ready : downstream accepts result
//   diff      : difference, registered
//   bout      : borrow-out, registered; 1 iff a < b + bin
module ripple_borrow_subtractor_seq
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int           IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    sub_state_t      state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;
    logic             bw;
    logic             d;
    logic             bw_next;

    // The single shared cell walks across the latched operands one bit per cycle.
    full_subtractor_bit u_cell (
        .a   (a_q[idx]),
        .b   (b_q[idx]),
        .bin (bw),
        .d   (d),
        .bout(bw_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            idx       <= '0;
            bw        <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        bw       <= bin;
                        idx      <= '0;
                        diff     <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff[idx] <= d;
                    bw        <= bw_next;
                    idx       <= idx + IW'(1);
                    if (idx == LAST) begin
                        bout      <= bw_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ripple_borrow_subtractor_seq.md
Name: ripple_borrow_subtractor_seq

Overview:
Bit-serial subtractor, the inverse operation of the team's combinational ripple-carry adder. Computes DIFF = A - B - BIN (mod 2^WIDTH) and the borrow-out BOUT, one bit per clock, LSB first, through a registered borrow.
Operands enter and results leave through valid/ready handshakes, so the block sits in a streaming datapath. It trades WIDTH cycles of latency for a single full-subtractor cell.

Parameters:
WIDTH, 3, operand/result width in bits (legal range 1..32)

Ports:
CLK  input  1  clock, rising-edge active
RST_N  input  1  reset, asynchronous assert, active-low
IN_VALID  input  1  operand bundle valid
IN_READY  output  1  block can accept operands
A  input  WIDTH  minuend
B  input  WIDTH  subtrahend
BIN  input  1  borrow-in
OUT_VALID  output  1  result valid
OUT_READY  input  1  downstream accepts result
DIFF  output  WIDTH  difference, registered
BOUT  output  1  borrow-out, registered; 1 iff A < B + BIN (unsigned)

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, IN_READY=1, OUT_VALID=0, DIFF=0, BOUT=0, bit index=0, internal borrow=0, operand registers=0.
- FSM states and transitions:
  - IDLE: IN_READY=1. On IN_VALID&IN_READY at a rising edge: latch A, B; borrow<=BIN; index<=0; DIFF<=0; go to RUN.
  - RUN: IN_READY=0, OUT_VALID=0. Each cycle, for bit i=index:
    - d = a[i]^b[i]^bw
    - bw_next = (~a[i]&b[i]) | (~(a[i]^b[i])&bw)
    - DIFF[i]<=d; borrow<=bw_next; index<=index+1.
    - When index==WIDTH-1: BOUT<=bw_next; go to DONE.
  - DONE: OUT_VALID=1; DIFF/BOUT held stable. On OUT_READY: go to IDLE. OUT_READY low stalls indefinitely with outputs unchanged.
- Latency: operands accepted at edge t. OUT_VALID rises after edge t+WIDTH. IN_READY is high again the cycle after the result handshake.
- Throughput: one operation per WIDTH+2 cycles with OUT_READY tied high. No overlap of operations.
- IN_VALID is ignored outside IDLE. A/B/BIN may change freely after acceptance.
- OUT_READY is ignored outside DONE.
- DIFF bits not yet computed read 0 during RUN. Consumers must sample only when OUT_VALID=1.
- Index counter width: $clog2(WIDTH) bits, minimum 1. For WIDTH=1, RUN lasts exactly one cycle.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values. The partial result is discarded and OUT_VALID is never asserted for it.
- All outputs come directly from flops; there is no combinational input-to-output path.

Decomposition:
- Package sub_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t
  - localparam default width constant shared with the adder bench.
- Sub-module full_subtractor_bit: purely combinational cell. Inputs a, b, bin; outputs d, bout. Instantiated once and fed by index-selected operand bits.

Test Plan:
- WIDTH=3, A=5, B=3, BIN=0, OUT_READY=1 -> OUT_VALID rises 3 cycles after accept; DIFF=2, BOUT=0.
- A=3, B=5, BIN=0 -> DIFF=6, BOUT=1. Then A=0, B=0, BIN=1 -> DIFF=7, BOUT=1. Then A=7, B=7, BIN=1 -> DIFF=7, BOUT=1.
- Backpressure: A=6, B=1, BIN=1, OUT_READY held low 10 cycles -> OUT_VALID=1 and DIFF=4, BOUT=0 stable throughout. IN_READY stays 0, and IN_VALID pulses during the stall are ignored.
- Reset mid-operation: assert RST_N=0 one cycle into RUN -> outputs reach reset values without a clock edge. After release, IN_READY=1 and no spurious OUT_VALID.
- Exhaustive: all 128 (A,B,BIN) combinations at WIDTH=3, with random OUT_READY -> every result matches golden {BOUT,DIFF} = {1'b0,A} - B - BIN in 4-bit two's-complement. Exactly one result per accepted operand.
- WIDTH=1 and WIDTH=8 builds: spot values 1-1-0 -> DIFF=0, BOUT=0, and 8'h00-8'h01-0 -> DIFF=8'hFF, BOUT=1. Latency equals WIDTH in both builds.
